// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: command-driven sequencer around a Gray-code counter.
// Accepts CLEAR/LOAD/RUN_UP/RUN_DOWN over a valid/ready handshake, runs a
// programmed number of Gray steps with pause/abort, and pulses done and wrap.
module gray_seq_ctrl #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_arg,
    input  logic                  pause,
    input  logic                  abort,
    output logic [DATA_WIDTH-1:0] gray_out,
    output logic [DATA_WIDTH-1:0] bin_out,
    output logic                  busy,
    output logic                  done,
    output logic                  wrap
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;

    localparam logic [DATA_WIDTH-1:0] ZERO    = '0;
    localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] MAX_VAL = '1;

    state_t                r_state;
    state_t                w_stateNext;
    logic [DATA_WIDTH-1:0] r_gray;
    logic [DATA_WIDTH-1:0] r_bin;
    logic [DATA_WIDTH-1:0] r_remain;
    logic                  r_dirDown;
    logic                  r_done;
    logic                  r_wrap;

    logic [DATA_WIDTH-1:0] w_grayNext;
    logic [DATA_WIDTH-1:0] w_binNext;
    logic [DATA_WIDTH-1:0] w_remainNext;
    logic                  w_dirDownNext;
    logic                  w_doneNext;
    logic                  w_wrapNext;
    logic [DATA_WIDTH-1:0] w_argBin;
    logic [DATA_WIDTH-1:0] w_stepBin;
    logic                  w_stepWraps;

    // Binary equivalent of a LOAD argument: each bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_argBin = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_argBin[i] = ^(cmd_arg >> i);
        end
    end

    // Candidate next binary value for a single step in the latched direction, and whether it wraps.
    always_comb begin
        w_stepBin   = r_dirDown ? (r_bin - ONE) : (r_bin + ONE);
        w_stepWraps = r_dirDown ? (r_bin == ZERO) : (r_bin == MAX_VAL);
    end

    // Next-state and next-datapath logic; everything holds unless a command or step changes it.
    always_comb begin
        w_stateNext   = r_state;
        w_grayNext    = r_gray;
        w_binNext     = r_bin;
        w_remainNext  = r_remain;
        w_dirDownNext = r_dirDown;
        w_wrapNext    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_CLEAR: begin
                            w_grayNext  = '0;
                            w_binNext   = '0;
                            w_stateNext = S_DONE;
                        end
                        OP_LOAD: begin
                            w_grayNext  = cmd_arg;
                            w_binNext   = w_argBin;
                            w_stateNext = S_DONE;
                        end
                        default: begin
                            if (cmd_arg == ZERO) begin
                                w_stateNext = S_DONE;
                            end else begin
                                w_remainNext  = cmd_arg;
                                w_dirDownNext = cmd_op[0];
                                w_stateNext   = S_RUN;
                            end
                        end
                    endcase
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_stateNext = S_DONE;
                end else if (!pause) begin
                    w_binNext    = w_stepBin;
                    w_grayNext   = w_stepBin ^ (w_stepBin >> 1);
                    w_remainNext = r_remain - ONE;
                    w_wrapNext   = w_stepWraps;
                    if (r_remain == ONE) begin
                        w_stateNext = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_stateNext = S_IDLE;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
        w_doneNext = (w_stateNext == S_DONE);
    end

    // State and datapath registers with synchronous active-low reset that wins over any run.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_gray    <= '0;
            r_bin     <= '0;
            r_remain  <= '0;
            r_dirDown <= 1'b0;
            r_done    <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_gray    <= w_grayNext;
            r_bin     <= w_binNext;
            r_remain  <= w_remainNext;
            r_dirDown <= w_dirDownNext;
            r_done    <= w_doneNext;
            r_wrap    <= w_wrapNext;
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign gray_out  = r_gray;
    assign bin_out   = r_bin;
    assign done      = r_done;
    assign wrap      = r_wrap;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb_gray_seq_ctrl: self-checking bench for gray_seq_ctrl (DATA_WIDTH=4).
// Command table, hand-written multi-cycle sequences, and a randomized run
// against a plain-arithmetic reference model.
module tb_gray_seq_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         cmdValid = 1'b0;
    logic         cmdReady;
    logic [1:0]   cmdOp = 2'b00;
    logic [W-1:0] cmdArg = '0;
    logic         pauseIn = 1'b0;
    logic         abortIn = 1'b0;
    logic [W-1:0] grayOut;
    logic [W-1:0] binOut;
    logic         busyOut;
    logic         doneOut;
    logic         wrapOut;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] arg;
        logic [W-1:0] expGray;
        logic [W-1:0] expBin;
        int           expWraps;
        int           expLat;
    } vec_t;

    vec_t         vecs[10];
    logic [W-1:0] upSeq[15];

    int mBin;
    int mLeft;
    int mDir;
    bit mRunning;
    bit mDoneShown;
    bit mWrap;

    gray_seq_ctrl #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmdValid),
        .cmd_ready (cmdReady),
        .cmd_op    (cmdOp),
        .cmd_arg   (cmdArg),
        .pause     (pauseIn),
        .abort     (abortIn),
        .gray_out  (grayOut),
        .bin_out   (binOut),
        .busy      (busyOut),
        .done      (doneOut),
        .wrap      (wrapOut)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        resetn   = 1'b0;
        cmdValid = 1'b0;
        pauseIn  = 1'b0;
        abortIn  = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] arg);
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdArg   = arg;
        tick();
        cmdValid = 1'b0;
    endtask

    // Issue one command and wait (bounded) for done, counting wraps and edges.
    task automatic runCommand(input logic [1:0] op, input logic [W-1:0] arg,
                              output int lat, output int wraps);
        logic [W-1:0] prevGray;
        prevGray = grayOut;
        applyStimulus(op, arg);
        lat   = 0;
        wraps = int'(wrapOut);
        while (doneOut !== 1'b1 && lat < 40) begin
            prevGray = grayOut;
            tick();
            lat++;
            wraps += int'(wrapOut);
            checkOutput("gray_one_bit", 32'($countones(grayOut ^ prevGray) <= 1), 32'd1);
        end
        if (lat >= 40) begin
            checkOutput("done_timeout", 32'(lat), 32'd0);
        end
    endtask

    function automatic int grayToBinRef(input int g);
        for (int b = 0; b < (1 << W); b++) begin
            if ((b ^ (b >> 1)) == g) return b;
        end
        return -1;
    endfunction

    // Advance the reference model by one clock edge given the current inputs.
    task automatic modelStep();
        bit wasDone;
        int old;
        wasDone    = mDoneShown;
        mDoneShown = 0;
        mWrap      = 0;
        if (!mRunning && !wasDone) begin
            if (cmdValid) begin
                if (cmdOp == 2'b00) begin
                    mBin = 0;
                    mDoneShown = 1;
                end else if (cmdOp == 2'b01) begin
                    mBin = grayToBinRef(int'(cmdArg));
                    mDoneShown = 1;
                end else if (cmdArg == 0) begin
                    mDoneShown = 1;
                end else begin
                    mLeft    = int'(cmdArg);
                    mDir     = (cmdOp == 2'b11) ? -1 : 1;
                    mRunning = 1;
                end
            end
        end else if (mRunning) begin
            if (abortIn) begin
                mRunning   = 0;
                mDoneShown = 1;
            end else if (!pauseIn) begin
                old   = mBin;
                mBin  = (mBin + mDir + (1 << W)) % (1 << W);
                mWrap = (old - mBin == (1 << W) - 1) || (mBin - old == (1 << W) - 1);
                mLeft--;
                if (mLeft == 0) begin
                    mRunning   = 0;
                    mDoneShown = 1;
                end
            end
        end
    endtask

    initial begin
        int lat;
        int wraps;

        vecs[0] = '{2'b10, 4'hF, 4'h8, 4'hF, 0, 15};
        vecs[1] = '{2'b10, 4'h1, 4'h0, 4'h0, 1, 1};
        vecs[2] = '{2'b01, 4'hC, 4'hC, 4'h8, 0, 0};
        vecs[3] = '{2'b11, 4'h2, 4'h5, 4'h6, 0, 2};
        vecs[4] = '{2'b00, 4'h7, 4'h0, 4'h0, 0, 0};
        vecs[5] = '{2'b11, 4'h1, 4'h8, 4'hF, 1, 1};
        vecs[6] = '{2'b10, 4'h0, 4'h8, 4'hF, 0, 0};
        vecs[7] = '{2'b01, 4'h5, 4'h5, 4'h6, 0, 0};
        vecs[8] = '{2'b10, 4'h3, 4'hD, 4'h9, 0, 3};
        vecs[9] = '{2'b11, 4'hF, 4'hF, 4'hA, 1, 15};
        upSeq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                  4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

        resetDut();
        checkOutput("reset_gray", 32'(grayOut), 32'h0);
        checkOutput("reset_bin", 32'(binOut), 32'h0);
        checkOutput("reset_done", 32'(doneOut), 32'h0);
        checkOutput("reset_wrap", 32'(wrapOut), 32'h0);
        checkOutput("reset_ready", 32'(cmdReady), 32'h1);
        checkOutput("reset_busy", 32'(busyOut), 32'h0);

        // Full RUN_UP 15 sequence, checked cycle by cycle.
        applyStimulus(2'b10, 4'hF);
        checkOutput("up15_start_gray", 32'(grayOut), 32'h0);
        checkOutput("up15_start_busy", 32'(busyOut), 32'h1);
        for (int k = 0; k < 15; k++) begin
            tick();
            checkOutput("up15_gray", 32'(grayOut), 32'(upSeq[k]));
            checkOutput("up15_done", 32'(doneOut), 32'((k == 14) ? 1 : 0));
        end
        tick();
        checkOutput("up15_ready_after", 32'(cmdReady), 32'h1);
        checkOutput("up15_done_drop", 32'(doneOut), 32'h0);

        // Table of commands applied back to back from a fresh reset.
        resetDut();
        for (int i = 0; i < 10; i++) begin
            checkOutput("vec_ready_before", 32'(cmdReady), 32'h1);
            runCommand(vecs[i].op, vecs[i].arg, lat, wraps);
            checkOutput("vec_gray", 32'(grayOut), 32'(vecs[i].expGray));
            checkOutput("vec_bin", 32'(binOut), 32'(vecs[i].expBin));
            checkOutput("vec_wraps", 32'(wraps), 32'(vecs[i].expWraps));
            checkOutput("vec_latency", 32'(lat), 32'(vecs[i].expLat));
            tick();
            checkOutput("vec_done_pulse", 32'(doneOut), 32'h0);
            checkOutput("vec_wrap_pulse", 32'(wrapOut), 32'h0);
        end

        // Pause for three cycles after step 2 of RUN_UP 4.
        applyStimulus(2'b00, 4'h0);
        tick();
        applyStimulus(2'b10, 4'h4);
        tick();
        checkOutput("pause_step1", 32'(grayOut), 32'h1);
        tick();
        checkOutput("pause_step2", 32'(grayOut), 32'h3);
        pauseIn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("pause_hold_gray", 32'(grayOut), 32'h3);
            checkOutput("pause_hold_busy", 32'(busyOut), 32'h1);
        end
        pauseIn = 1'b0;
        tick();
        checkOutput("pause_step3", 32'(grayOut), 32'h2);
        checkOutput("pause_no_done", 32'(doneOut), 32'h0);
        tick();
        checkOutput("pause_step4", 32'(grayOut), 32'h6);
        checkOutput("pause_done", 32'(doneOut), 32'h1);
        tick();

        // Abort after step 3 of RUN_UP 10.
        applyStimulus(2'b00, 4'h0);
        tick();
        applyStimulus(2'b10, 4'hA);
        tick();
        tick();
        tick();
        abortIn = 1'b1;
        tick();
        abortIn = 1'b0;
        checkOutput("abort_gray", 32'(grayOut), 32'h2);
        checkOutput("abort_bin", 32'(binOut), 32'h3);
        checkOutput("abort_done", 32'(doneOut), 32'h1);
        tick();
        checkOutput("abort_ready", 32'(cmdReady), 32'h1);
        checkOutput("abort_gray_held", 32'(grayOut), 32'h2);

        // Reset in the middle of a run.
        applyStimulus(2'b10, 4'hA);
        tick();
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        checkOutput("midreset_gray", 32'(grayOut), 32'h0);
        checkOutput("midreset_bin", 32'(binOut), 32'h0);
        checkOutput("midreset_ready", 32'(cmdReady), 32'h1);
        checkOutput("midreset_busy", 32'(busyOut), 32'h0);
        checkOutput("midreset_done", 32'(doneOut), 32'h0);

        // A LOAD presented while busy must be dropped.
        applyStimulus(2'b10, 4'h3);
        cmdValid = 1'b1;
        cmdOp    = 2'b01;
        cmdArg   = 4'hF;
        tick();
        tick();
        tick();
        cmdValid = 1'b0;
        checkOutput("busy_drop_done", 32'(doneOut), 32'h1);
        tick();
        checkOutput("busy_drop_gray", 32'(grayOut), 32'h2);
        checkOutput("busy_drop_bin", 32'(binOut), 32'h3);

        // Randomized traffic compared every cycle against the reference model.
        resetDut();
        mBin = 0;
        mLeft = 0;
        mDir = 1;
        mRunning = 0;
        mDoneShown = 0;
        mWrap = 0;
        for (int c = 0; c < 600; c++) begin
            cmdValid = ($urandom_range(0, 1) == 1);
            cmdOp    = 2'($urandom_range(0, 3));
            cmdArg   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
            pauseIn  = ($urandom_range(0, 3) == 0);
            abortIn  = ($urandom_range(0, 11) == 0);
            modelStep();
            tick();
            checkOutput("rand_bin", 32'(binOut), 32'(mBin));
            checkOutput("rand_gray", 32'(grayOut), 32'(mBin ^ (mBin >> 1)));
            checkOutput("rand_busy", 32'(busyOut), 32'(mRunning || mDoneShown));
            checkOutput("rand_ready", 32'(cmdReady), 32'(!(mRunning || mDoneShown)));
            checkOutput("rand_done", 32'(doneOut), 32'(mDoneShown));
            checkOutput("rand_wrap", 32'(wrapOut), 32'(mWrap));
        end
        cmdValid = 1'b0;
        pauseIn  = 1'b0;
        abortIn  = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
